// File: rtl/interp_sequencer_pkg.sv
// interp_sequencer_pkg: state encoding and fixed layout constants for the interpolation sequencer
package interp_sequencer_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_HPASS,
    S_HDRAIN,
    S_VPASS,
    S_VDRAIN,
    S_DONE
  } state_t;
  localparam int VBASE = 16;
  localparam int NUM_SRC = 4;
endpackage

// File: rtl/interp_valid_pipe.sv
// interp_valid_pipe: LAT-deep delay line tracking FIR issue tags until their results are registered
module interp_valid_pipe #(
  parameter int LAT = 2,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sr [LAT];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < LAT; i++) sr[i] <= sr[i-1];
    end
  end
  assign q = sr[LAT-1];
endmodule

// File: rtl/interp_sequencer.sv
// interp_sequencer: FSM pacing row fill, horizontal and vertical FIR passes of the subpixel interpolator
module interp_sequencer
  import interp_sequencer_pkg::*;
#(
  parameter int NUM_PIXEL = 8,
  parameter int TAPS = 8,
  parameter int FIR_LAT = 2,
  parameter int SEL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             row_valid,
  output logic             row_ready,
  output logic             in_load,
  output logic [SEL_W-1:0] mux_sel,
  output logic             half_load,
  output logic             out_load,
  output logic [SEL_W-1:0] out_idx,
  output logic             busy,
  output logic             done
);
  localparam int ROWS = NUM_PIXEL + TAPS - 1;
  localparam int HSTART = TAPS / 2 - 1;
  localparam int VLAST = VBASE + NUM_SRC * NUM_PIXEL - 1;
  state_t state, state_n;
  logic [SEL_W-1:0] cnt;
  logic [2:0] pipe_q;
  logic issue, is_out;
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = start ? S_FILL : S_IDLE;
      S_FILL:   state_n = (row_valid && cnt == SEL_W'(ROWS - 1)) ? S_HPASS : S_FILL;
      S_HPASS:  state_n = (mux_sel == SEL_W'(ROWS - 1)) ? S_HDRAIN : S_HPASS;
      S_HDRAIN: state_n = (cnt == SEL_W'(FIR_LAT - 1)) ? S_VPASS : S_HDRAIN;
      S_VPASS:  state_n = (mux_sel == SEL_W'(VLAST)) ? S_VDRAIN : S_VPASS;
      S_VDRAIN: state_n = (cnt == SEL_W'(FIR_LAT - 1)) ? S_DONE : S_VDRAIN;
      default:  state_n = S_IDLE;
    endcase
  end
  // mux_sel doubles as the issue counter; vertical sources are contiguous from VBASE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      mux_sel <= '0;
      out_idx <= '0;
    end else begin
      state <= state_n;
      cnt <= (state_n != state) ? '0 : (state == S_FILL) ? cnt + SEL_W'(row_valid) : cnt + SEL_W'(1);
      if (state_n == S_HPASS) mux_sel <= (state == S_HPASS) ? mux_sel + SEL_W'(1) : '0;
      else if (state_n == S_VPASS) mux_sel <= (state == S_VPASS) ? mux_sel + SEL_W'(1) : SEL_W'(VBASE);
      if (out_load) out_idx <= out_idx + SEL_W'(1);
      else if (state == S_IDLE && start) out_idx <= '0;
    end
  end
  assign issue = state == S_HPASS || state == S_VPASS;
  assign is_out = state == S_VPASS || (state == S_HPASS && mux_sel >= SEL_W'(HSTART) && mux_sel < SEL_W'(HSTART + NUM_PIXEL));
  interp_valid_pipe #(.LAT(FIR_LAT), .W(3)) u_pipe (
    .clk(clk),
    .rst(rst),
    .d({issue, state == S_HPASS, is_out}),
    .q(pipe_q)
  );
  assign half_load = pipe_q[2] & pipe_q[1];
  assign out_load = pipe_q[2] & pipe_q[0];
  assign row_ready = state == S_FILL;
  assign in_load = row_valid & row_ready;
  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
endmodule

// File: tb/tb_interp_sequencer.sv
// tb_interp_sequencer: randomized bench against a schedule model derived from fill completion time
module tb_interp_sequencer;
  localparam int L = 2;
  localparam int NP = 8;
  localparam int ROWS = 15;
  localparam int HS = 3;
  localparam int NV = 32;
  logic clk = 0, rst = 1, start = 0, row_valid = 0;
  logic row_ready, in_load, half_load, out_load, busy, done;
  logic [7:0] mux_sel, out_idx;
  int checks = 0, failures = 0;

  interp_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .row_valid(row_valid), .row_ready(row_ready),
    .in_load(in_load), .mux_sel(mux_sel), .half_load(half_load), .out_load(out_load),
    .out_idx(out_idx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rr"}, row_ready, 0);
    chk({tag, "_in"}, in_load, 0);
    chk({tag, "_mux"}, mux_sel, 0);
    chk({tag, "_half"}, half_load, 0);
    chk({tag, "_out"}, out_load, 0);
    chk({tag, "_idx"}, out_idx, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // The expected schedule hangs off the cycle of the last accepted row (fill_end)
  task automatic run_block(input int mode, input int abort_c);
    int rows = 0, fill_end = -1, h0, v0, dc = 0, nexp = 0;
    int nin = 0, nhalf = 0, nout = 0, ndone = 0, td = -1;
    bit rv, rr, hl, ol, fin = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (abort_c != 0 && c == abort_c) return;
      h0 = fill_end < 0 ? 100000 : fill_end + 1;
      v0 = h0 + ROWS + L;
      dc = v0 + NV + L;
      start = (c == 0) || (c <= dc && (c == 10 || c == dc || $urandom_range(0, 7) == 0));
      rv = mode == 0 ? 1'b1 : mode == 1 ? bit'(c % 2) : bit'($urandom_range(0, 1));
      row_valid = rv;
      #1;
      rr = c >= 1 && rows < ROWS;
      chk("row_ready", row_ready, rr);
      chk("in_load", in_load, rr & rv);
      chk("busy", busy, c >= 1 && c <= dc);
      chk("done", done, c == dc);
      hl = c >= h0 + L && c < h0 + L + ROWS;
      chk("half_load", half_load, hl);
      ol = (c >= h0 + HS + L && c < h0 + HS + NP + L) || (c >= v0 + L && c < v0 + NV + L);
      chk("out_load", out_load, ol);
      if (ol) begin
        chk("out_idx", out_idx, nexp);
        nexp++;
      end
      if (c >= h0 && c < h0 + ROWS) chk("mux_h", mux_sel, c - h0);
      if (c >= v0 && c < v0 + NV) chk("mux_v", mux_sel, 16 + c - v0);
      nin += int'(in_load);
      nhalf += int'(half_load);
      nout += int'(out_load);
      ndone += int'(done);
      if (done) td = c;
      if (rr && rv) begin
        rows++;
        if (rows == ROWS) fill_end = c;
      end
      if (c == dc + 1) begin
        fin = 1;
        break;
      end
    end
    start = 0;
    chk("finished", fin, 1);
    chk("in_cnt", nin, ROWS);
    chk("half_cnt", nhalf, ROWS);
    chk("out_cnt", nout, 40);
    chk("done_cnt", ndone, 1);
    chk("done_t", td, mode == 0 ? 67 : mode == 1 ? 81 : dc);
  endtask

  task automatic reset_and_idle();
    start = 0;
    row_valid = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check_idle_outputs("rst");
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      row_valid = bit'($urandom_range(0, 1));
      #1;
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_in", in_load, 0);
    end
    row_valid = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("por");
    rst = 0;
    run_block(0, 0);
    run_block(1, 0);
    for (int i = 0; i < 3; i++) run_block(2, 0);
    run_block(0, 40);
    reset_and_idle();
    run_block(2, 0);
    run_block(0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
